mips_multicycle_ctrl: RTL and testbench

- Moore-style control FSM for the multicycle MIPS datapath.
- Sequences one instruction over 3–5 states using the shared ALU, a single unified memory port, and the IR/PC/A/B/ALUOut registers.
- Decodes op/funct from the IR and supports the same instruction set and aluop encoding as the single-cycle decoder.
- Stalls on a memory-ready handshake.

---
 rtl/mips_multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath.
module mips_multicycle_ctrl #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BEQEX = 4'd8, BNEEX = 4'd9,
        IMMEX = 4'd10, IMMWB = 4'd11, JEX = 4'd12, JALEX = 4'd13, JREX = 4'd14,
        BAD = 4'd15
    } state_t;
    state_t st, nx, dec;
    logic rdy;
    logic [3:0] imm_op;
    assign rdy = MEM_WAIT ? mem_ready : 1'b1;
    // No legal opcode decodes to FETCH, so that outcome doubles as the illegal flag.
    always_comb begin
        case (op)
            6'b100011, 6'b101011: dec = MEMADR;
            6'b000000: dec = funct == 6'b001000 ? JREX : EXECUTE;
            6'b000100: dec = BEQEX;
            6'b000101: dec = BNEEX;
            6'b001000, 6'b001101, 6'b001100, 6'b001110, 6'b001111: dec = IMMEX;
            6'b000010: dec = JEX;
            6'b000011: dec = JALEX;
            default: dec = FETCH;
        endcase
    end
    always_comb begin
        case (op)
            6'b001101: imm_op = 4'b0100;
            6'b001100: imm_op = 4'b0101;
            6'b001110: imm_op = 4'b0111;
            6'b001111: imm_op = 4'b0011;
            default: imm_op = 4'b0000;
        endcase
    end
    always_comb begin
        case (st)
            FETCH: nx = rdy ? DECODE : FETCH;
            DECODE: nx = dec;
            MEMADR: nx = op == 6'b100011 ? MEMRD : MEMWR;
            MEMRD: nx = rdy ? MEMWB : MEMRD;
            MEMWR: nx = rdy ? FETCH : MEMWR;
            EXECUTE: nx = ALUWB;
            IMMEX: nx = IMMWB;
            default: nx = FETCH;
        endcase
    end
    always_ff @(posedge clk)
        st <= !reset ? FETCH : nx;
    // Outputs decode the current state, gated to zero while reset is held low.
    always_comb begin
        pcwrite = 1'b0;
        branch = 1'b0;
        branch_ne = 1'b0;
        iord = 1'b0;
        memwrite = 1'b0;
        irwrite = 1'b0;
        regdst = 2'b00;
        memtoreg = 2'b00;
        regwrite = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        pcsrc = 2'b00;
        aluop = 4'b0000;
        illegal_op = 1'b0;
        if (reset) begin
            case (st)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = rdy;
                    pcwrite = rdy;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    illegal_op = dec == FETCH;
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg = 2'b01;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord = 1'b1;
                    memwrite = 1'b1;
                end
                EXECUTE: begin
                    alusrca = 1'b1;
                    aluop = 4'b0010;
                end
                ALUWB: begin
                    regdst = 2'b01;
                    regwrite = 1'b1;
                end
                BEQEX, BNEEX: begin
                    alusrca = 1'b1;
                    aluop = 4'b0001;
                    pcsrc = 2'b01;
                    branch = st == BEQEX;
                    branch_ne = st == BNEEX;
                end
                IMMEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop = imm_op;
                end
                IMMWB: regwrite = 1'b1;
                JEX: begin
                    pcsrc = 2'b10;
                    pcwrite = 1'b1;
                end
                JALEX: begin
                    regdst = 2'b10;
                    memtoreg = 2'b10;
                    regwrite = 1'b1;
                    pcsrc = 2'b10;
                    pcwrite = 1'b1;
                end
                JREX: begin
                    pcsrc = 2'b11;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign state = reset ? st : 4'd0;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed instruction sequences with hand-computed state and output vectors.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0, reset = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic pcwrite, branch, branch_ne, iord, memwrite, irwrite, regwrite, alusrca, illegal_op;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [3:0] aluop, state;
    logic [20:0] outv;
    int n_cmp = 0, n_bad = 0;
    // Vector layout: pcw br bne iord mw irw _ regdst _ memtoreg _ rw asa _ alusrcb _ pcsrc _ aluop _ ill
    localparam logic [20:0] V_ZERO  = 21'b000000_00_00_00_00_00_0000_0;
    localparam logic [20:0] V_FRDY  = 21'b100001_00_00_00_01_00_0000_0;
    localparam logic [20:0] V_FWAIT = 21'b000000_00_00_00_01_00_0000_0;
    localparam logic [20:0] V_DEC   = 21'b000000_00_00_00_11_00_0000_0;
    localparam logic [20:0] V_DILL  = 21'b000000_00_00_00_11_00_0000_1;
    localparam logic [20:0] V_MADR  = 21'b000000_00_00_01_10_00_0000_0;
    localparam logic [20:0] V_MRD   = 21'b000100_00_00_00_00_00_0000_0;
    localparam logic [20:0] V_MWB   = 21'b000000_00_01_10_00_00_0000_0;
    localparam logic [20:0] V_MWR   = 21'b000110_00_00_00_00_00_0000_0;
    localparam logic [20:0] V_EXE   = 21'b000000_00_00_01_00_00_0010_0;
    localparam logic [20:0] V_ALUWB = 21'b000000_01_00_10_00_00_0000_0;
    localparam logic [20:0] V_BEQ   = 21'b010000_00_00_01_00_01_0001_0;
    localparam logic [20:0] V_BNE   = 21'b001000_00_00_01_00_01_0001_0;
    localparam logic [20:0] V_ORI   = 21'b000000_00_00_01_10_00_0100_0;
    localparam logic [20:0] V_LUI   = 21'b000000_00_00_01_10_00_0011_0;
    localparam logic [20:0] V_IMMWB = 21'b000000_00_00_10_00_00_0000_0;
    localparam logic [20:0] V_JAL   = 21'b100000_10_10_10_00_10_0000_0;
    localparam logic [20:0] V_JR    = 21'b100000_00_00_00_00_11_0000_0;

    mips_multicycle_ctrl #(.MEM_WAIT(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .illegal_op(illegal_op), .state(state)
    );

    assign outv = {pcwrite, branch, branch_ne, iord, memwrite, irwrite, regdst, memtoreg,
                   regwrite, alusrca, alusrcb, pcsrc, aluop, illegal_op};

    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then check state and outputs mid-cycle.
    task automatic cyc(input string tag, input logic rst, input logic mr, input logic [5:0] o,
                       input logic [5:0] f, input logic [3:0] es, input logic [20:0] eo);
        @(negedge clk);
        reset = rst;
        mem_ready = mr;
        op = o;
        funct = f;
        #1;
        n_cmp++;
        assert (state === es) else begin
            n_bad++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, es);
        end
        n_cmp++;
        assert (outv === eo) else begin
            n_bad++;
            $error("FAIL %s outputs: got %b expected %b", tag, outv, eo);
        end
    endtask

    initial begin
        cyc("rst0", 1'b0, 1'b1, 6'd0, 6'b100000, 4'd0, V_ZERO);
        cyc("rst1", 1'b0, 1'b1, 6'd0, 6'b100000, 4'd0, V_ZERO);
        cyc("add_f", 1'b1, 1'b1, 6'd0, 6'b100000, 4'd0, V_FRDY);
        cyc("add_d", 1'b1, 1'b1, 6'd0, 6'b100000, 4'd1, V_DEC);
        cyc("add_ex", 1'b1, 1'b1, 6'd0, 6'b100000, 4'd6, V_EXE);
        cyc("add_wb", 1'b1, 1'b1, 6'd0, 6'b100000, 4'd7, V_ALUWB);
        cyc("lw_f", 1'b1, 1'b1, 6'b100011, 6'd0, 4'd0, V_FRDY);
        cyc("lw_d", 1'b1, 1'b1, 6'b100011, 6'd0, 4'd1, V_DEC);
        cyc("lw_adr", 1'b1, 1'b1, 6'b100011, 6'd0, 4'd2, V_MADR);
        cyc("lw_rd0", 1'b1, 1'b0, 6'b100011, 6'd0, 4'd3, V_MRD);
        cyc("lw_rd1", 1'b1, 1'b0, 6'b100011, 6'd0, 4'd3, V_MRD);
        cyc("lw_rd2", 1'b1, 1'b1, 6'b100011, 6'd0, 4'd3, V_MRD);
        cyc("lw_wb", 1'b1, 1'b1, 6'b100011, 6'd0, 4'd4, V_MWB);
        cyc("sw_fw", 1'b1, 1'b0, 6'b101011, 6'd0, 4'd0, V_FWAIT);
        cyc("sw_f", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd0, V_FRDY);
        cyc("sw_d", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd1, V_DEC);
        cyc("sw_adr", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd2, V_MADR);
        cyc("sw_wr", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd5, V_MWR);
        cyc("beq_f", 1'b1, 1'b1, 6'b000100, 6'd0, 4'd0, V_FRDY);
        cyc("beq_d", 1'b1, 1'b1, 6'b000100, 6'd0, 4'd1, V_DEC);
        cyc("beq_ex", 1'b1, 1'b1, 6'b000100, 6'd0, 4'd8, V_BEQ);
        cyc("bne_f", 1'b1, 1'b1, 6'b000101, 6'd0, 4'd0, V_FRDY);
        cyc("bne_d", 1'b1, 1'b1, 6'b000101, 6'd0, 4'd1, V_DEC);
        cyc("bne_ex", 1'b1, 1'b1, 6'b000101, 6'd0, 4'd9, V_BNE);
        cyc("ori_f", 1'b1, 1'b1, 6'b001101, 6'd0, 4'd0, V_FRDY);
        cyc("ori_d", 1'b1, 1'b1, 6'b001101, 6'd0, 4'd1, V_DEC);
        cyc("ori_ex", 1'b1, 1'b1, 6'b001101, 6'd0, 4'd10, V_ORI);
        cyc("ori_wb", 1'b1, 1'b1, 6'b001101, 6'd0, 4'd11, V_IMMWB);
        cyc("lui_f", 1'b1, 1'b1, 6'b001111, 6'd0, 4'd0, V_FRDY);
        cyc("lui_d", 1'b1, 1'b1, 6'b001111, 6'd0, 4'd1, V_DEC);
        cyc("lui_ex", 1'b1, 1'b1, 6'b001111, 6'd0, 4'd10, V_LUI);
        cyc("lui_wb", 1'b1, 1'b1, 6'b001111, 6'd0, 4'd11, V_IMMWB);
        cyc("jal_f", 1'b1, 1'b1, 6'b000011, 6'd0, 4'd0, V_FRDY);
        cyc("jal_d", 1'b1, 1'b1, 6'b000011, 6'd0, 4'd1, V_DEC);
        cyc("jal_ex", 1'b1, 1'b1, 6'b000011, 6'd0, 4'd13, V_JAL);
        cyc("jr_f", 1'b1, 1'b1, 6'd0, 6'b001000, 4'd0, V_FRDY);
        cyc("jr_d", 1'b1, 1'b1, 6'd0, 6'b001000, 4'd1, V_DEC);
        cyc("jr_ex", 1'b1, 1'b1, 6'd0, 6'b001000, 4'd14, V_JR);
        cyc("ill_f", 1'b1, 1'b1, 6'b111111, 6'd0, 4'd0, V_FRDY);
        cyc("ill_d", 1'b1, 1'b1, 6'b111111, 6'd0, 4'd1, V_DILL);
        cyc("ill_nx", 1'b1, 1'b0, 6'b111111, 6'd0, 4'd0, V_FWAIT);
        cyc("ab_f", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd0, V_FRDY);
        cyc("ab_d", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd1, V_DEC);
        cyc("ab_adr", 1'b1, 1'b0, 6'b101011, 6'd0, 4'd2, V_MADR);
        cyc("ab_wr", 1'b1, 1'b0, 6'b101011, 6'd0, 4'd5, V_MWR);
        cyc("ab_rst", 1'b0, 1'b1, 6'b101011, 6'd0, 4'd0, V_ZERO);
        cyc("ab_fetch", 1'b1, 1'b1, 6'b101011, 6'd0, 4'd0, V_FRDY);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
